posit_add_arbiter_es2: RTL

POSIT_ADD_ARBITER_ES2 -- requirements
Module: posit_add_arbiter_es2

---
 rtl/posit_add_arbiter_es2.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/posit_add_arbiter_es2.sv
// Round-robin front end sharing one pipelined posit adder among NREQ requesters.
// Define POSIT_ADD_ARB_STATS_EN to build saturating per-requester grant counters.
module posit_add_arbiter_es2 #(
  parameter int NREQ = 4,
  parameter int ADD_LATENCY = 8,
  parameter int POSIT_SERIALIZED_WIDTH_ES2 = 12,
  parameter int POSIT_SERIALIZED_WIDTH_SUM_ES2 = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES2-1:0] req_in1,
  input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES2-1:0] req_in2,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] add_in1,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] add_in2,
  output logic add_start,
  input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] add_result,
  input  logic add_done,
  output logic [NREQ-1:0] resp_valid,
  output logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] resp_result,
  input  logic flush,
  output logic flush_done,
  output logic tag_err,
  output logic [NREQ*16-1:0] grant_count
);
  localparam int PW = POSIT_SERIALIZED_WIDTH_ES2;
  localparam int IFW = $clog2(ADD_LATENCY + 2);
  localparam logic [15:0] BLANK_INIT = 16'(ADD_LATENCY);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e state_q, state_d;
  logic armed_q, armed_d;
  logic [2:0] rr_q, rr_d;
  logic [IFW-1:0] infl_q, infl_d;
  logic [15:0] blank_q, blank_d;
  logic start_q, start_d;
  logic [2:0] id_q, id_d;
  logic [PW-1:0] in1_q, in1_d;
  logic [PW-1:0] in2_q, in2_d;
  logic [3:0] tag_q [ADD_LATENCY];
  logic [3:0] tag_d [ADD_LATENCY];
  logic tag_err_q, tag_err_d;
  logic flush_done_q, flush_done_d;

  logic [7:0] valid_ext;
  logic [3:0] idx;
  logic gnt_v;
  logic [2:0] gnt_id;
  logic blank_on, tag_v, done_tag, resp_fire;

  always_comb begin
    valid_ext = '0;
    valid_ext[NREQ-1:0] = req_valid;
    gnt_v = 1'b0;
    gnt_id = '0;
    idx = '0;
    if (state_q == RUN && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = {1'b0, rr_q} + 4'(k);
        if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
        if (!gnt_v && valid_ext[idx[2:0]]) begin
          gnt_v = 1'b1;
          gnt_id = idx[2:0];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt_v && (gnt_id == 3'(i));
      resp_valid[i] = resp_fire && (tag_q[ADD_LATENCY-1][2:0] == 3'(i));
    end
  end

  always_comb begin
    start_d = gnt_v;
    id_d = gnt_v ? gnt_id : id_q;
    in1_d = in1_q;
    in2_d = in2_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_v && gnt_id == 3'(i)) begin
        in1_d = req_in1[i*PW +: PW];
        in2_d = req_in2[i*PW +: PW];
      end
    end
    rr_d = rr_q;
    if (gnt_v) rr_d = (gnt_id == 3'(NREQ-1)) ? 3'd0 : gnt_id + 3'd1;
  end

  // Tags ride alongside the adder so each done maps back to its requester.
  always_comb begin
    tag_d[0] = {start_q, id_q};
    for (int k = 1; k < ADD_LATENCY; k++) tag_d[k] = tag_q[k-1];
  end

  assign blank_on = blank_q != 16'd0;
  assign tag_v = tag_q[ADD_LATENCY-1][3];
  assign done_tag = add_done && tag_v;
  assign resp_fire = done_tag && !blank_on;

  always_comb begin
    blank_d = blank_on ? blank_q - 16'd1 : blank_q;
    tag_err_d = tag_err_q | (!blank_on && (add_done != tag_v));
    unique case ({gnt_v, done_tag})
      2'b10: infl_d = infl_q + IFW'(1);
      2'b01: infl_d = infl_q - IFW'(1);
      default: infl_d = infl_q;
    endcase
  end

  // armed marks a flush that has not yet produced its flush_done pulse.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
          armed_d = 1'b1;
        end
      end
      DRAIN: begin
        if (armed_q && infl_d == '0) begin
          state_d = DONE;
          armed_d = 1'b0;
        end else if (!armed_q && !flush) begin
          state_d = RUN;
        end
      end
      DONE: state_d = flush ? DRAIN : RUN;
      default: state_d = RUN;
    endcase
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      armed_q <= 1'b0;
      rr_q <= '0;
      infl_q <= '0;
      blank_q <= BLANK_INIT;
      start_q <= 1'b0;
      id_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      tag_err_q <= 1'b0;
      flush_done_q <= 1'b0;
      for (int k = 0; k < ADD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      rr_q <= rr_d;
      infl_q <= infl_d;
      blank_q <= blank_d;
      start_q <= start_d;
      id_q <= id_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      tag_err_q <= tag_err_d;
      flush_done_q <= flush_done_d;
      for (int k = 0; k < ADD_LATENCY; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign add_in1 = in1_q;
  assign add_in2 = in2_q;
  assign add_start = start_q;
  assign resp_result = add_result;
  assign flush_done = flush_done_q;
  assign tag_err = tag_err_q;

`ifdef POSIT_ADD_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_v && gnt_id == 3'(i) && cnt_q[i] != 16'hFFFF)
        cnt_d[i] = cnt_q[i] + 16'd1;
      grant_count[i*16 +: 16] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign grant_count = '0;
`endif

endmodule
